// File: rtl/pipe_pkg.sv
// pipe_pkg: state encoding and default widths shared by
// pipe_stage_reg and pipe_slot.
package pipe_pkg;

  localparam int DATA_W_D = 32;
  localparam int CTRL_W_D = 8;
  localparam int CNT_W_D  = 16;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_e;

  // Without the skid slot the single occupied state is FULL.
  localparam state_e ST_FULL = ST_ONE;

endpackage

// File: rtl/pipe_slot.sv
// pipe_slot: one data+ctrl register with load enable;
// clear zeroes ctrl only so data holds across a kill.
module pipe_slot
  import pipe_pkg::*;
#(
  parameter int DATA_W = DATA_W_D,
  parameter int CTRL_W = CTRL_W_D
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic              i_clr,
  input  logic [DATA_W-1:0] i_data,
  input  logic [CTRL_W-1:0] i_ctrl,
  output logic [DATA_W-1:0] o_data,
  output logic [CTRL_W-1:0] o_ctrl
);

  logic [DATA_W-1:0] r_data;
  logic [CTRL_W-1:0] r_ctrl;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_data <= '0;
      r_ctrl <= '0;
    end else if (i_clr) begin
      r_ctrl <= '0;
    end else if (i_load) begin
      r_data <= i_data;
      r_ctrl <= i_ctrl;
    end
  end

  assign o_data = r_data;
  assign o_ctrl = r_ctrl;

endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: valid/ready pipeline register with stall,
// flush and stall counter; PIPE_STAGE_SKID_EN adds a skid slot.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W = DATA_W_D,
  parameter int CTRL_W = CTRL_W_D,
  parameter int CNT_W  = CNT_W_D
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  input  logic              stall,
  input  logic              flush,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_e            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic              w_in_fire;
  logic              w_out_fire;
  logic              w_out_valid;
  logic              w_in_ready;
  logic              w_hd_load;
  logic              w_hd_clr;
  logic [DATA_W-1:0] w_hd_din;
  logic [CTRL_W-1:0] w_hd_cin;
  logic [DATA_W-1:0] w_hd_data;
  logic [CTRL_W-1:0] w_hd_ctrl;

  assign w_out_valid = (r_state != ST_EMPTY);
  assign w_out_fire  = w_out_valid & out_ready & !stall;
  assign w_in_fire   = in_valid & w_in_ready;

`ifdef PIPE_STAGE_SKID_EN

  logic              w_sk_load;
  logic              w_sk_clr;
  logic [DATA_W-1:0] w_sk_data;
  logic [CTRL_W-1:0] w_sk_ctrl;

  // Ready depends on registered state only.
  assign w_in_ready = rst & !stall & (r_state != ST_TWO);

  assign w_sk_load = !flush & (r_state == ST_ONE)
                   & w_in_fire & !w_out_fire;
  assign w_sk_clr  = flush
                   | ((r_state == ST_TWO) & w_out_fire);

  assign w_hd_load = !flush & (
      ((r_state == ST_EMPTY) & w_in_fire)
    | ((r_state == ST_ONE) & w_in_fire & w_out_fire)
    | ((r_state == ST_TWO) & w_out_fire));
  assign w_hd_clr  = flush | (w_out_fire & !w_hd_load);
  assign w_hd_din  = (r_state == ST_TWO) ? w_sk_data : in_data;
  assign w_hd_cin  = (r_state == ST_TWO) ? w_sk_ctrl : in_ctrl;

  pipe_slot #(
    .DATA_W (DATA_W),
    .CTRL_W (CTRL_W)
  ) u_skid (
    .clk    (clk),
    .rst    (rst),
    .i_load (w_sk_load),
    .i_clr  (w_sk_clr),
    .i_data (in_data),
    .i_ctrl (in_ctrl),
    .o_data (w_sk_data),
    .o_ctrl (w_sk_ctrl)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_EMPTY;
    end else if (flush) begin
      r_state <= ST_EMPTY;
    end else begin
      unique case (r_state)
        ST_EMPTY: begin
          if (w_in_fire) r_state <= ST_ONE;
        end
        ST_ONE: begin
          if (w_in_fire && !w_out_fire)
            r_state <= ST_TWO;
          else if (!w_in_fire && w_out_fire)
            r_state <= ST_EMPTY;
        end
        ST_TWO: begin
          if (w_out_fire) r_state <= ST_ONE;
        end
        default: r_state <= ST_EMPTY;
      endcase
    end
  end

`else

  assign w_in_ready = rst & !stall
                    & ((r_state == ST_EMPTY) | out_ready);

  assign w_hd_load = w_in_fire & !flush;
  assign w_hd_clr  = flush | (w_out_fire & !w_in_fire);
  assign w_hd_din  = in_data;
  assign w_hd_cin  = in_ctrl;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_EMPTY;
    end else if (flush) begin
      r_state <= ST_EMPTY;
    end else begin
      unique case (r_state)
        ST_EMPTY: begin
          if (w_in_fire) r_state <= ST_FULL;
        end
        ST_FULL: begin
          if (w_out_fire && !w_in_fire)
            r_state <= ST_EMPTY;
        end
        default: r_state <= ST_EMPTY;
      endcase
    end
  end

`endif

  pipe_slot #(
    .DATA_W (DATA_W),
    .CTRL_W (CTRL_W)
  ) u_head (
    .clk    (clk),
    .rst    (rst),
    .i_load (w_hd_load),
    .i_clr  (w_hd_clr),
    .i_data (w_hd_din),
    .i_ctrl (w_hd_cin),
    .o_data (w_hd_data),
    .o_ctrl (w_hd_ctrl)
  );

  // Back-pressure counter saturates and ignores flush.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (w_out_valid && (!out_ready || stall)
                 && (r_cnt != CNT_MAX)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = w_out_valid;
  assign out_data  = w_hd_data;
  assign out_ctrl  = w_out_valid ? w_hd_ctrl : '0;
  assign stall_cnt = r_cnt;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: queue scoreboard plus directed cases;
// honours PIPE_STAGE_SKID_EN like the design.
module tb_pipe_stage_reg;
  import pipe_pkg::*;

  localparam int DW = 32;
  localparam int CW = 8;
  localparam int NW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic          stall = 1'b0;
  logic          flush = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic [CW-1:0] in_ctrl = '0;

  logic          in_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic [CW-1:0] out_ctrl;
  logic [NW-1:0] stall_cnt;

  logic          in_ready4;
  logic          out_valid4;
  logic [DW-1:0] out_data4;
  logic [CW-1:0] out_ctrl4;
  logic [3:0]    stall_cnt4;

  typedef struct packed {
    logic [CW-1:0] c;
    logic [DW-1:0] d;
  } ent_t;

  ent_t        q[$];
  int          checks = 0;
  int          errors = 0;
  int unsigned exp_cnt = 0;
  int unsigned exp_cnt4 = 0;

  always #5 clk = ~clk;

  pipe_stage_reg #(
    .DATA_W (DW),
    .CTRL_W (CW),
    .CNT_W  (NW)
  ) u_dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_ctrl   (in_ctrl),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ctrl  (out_ctrl),
    .stall     (stall),
    .flush     (flush),
    .stall_cnt (stall_cnt)
  );

  pipe_stage_reg #(
    .DATA_W (DW),
    .CTRL_W (CW),
    .CNT_W  (4)
  ) u_dut4 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready4),
    .in_data   (in_data),
    .in_ctrl   (in_ctrl),
    .out_valid (out_valid4),
    .out_ready (out_ready),
    .out_data  (out_data4),
    .out_ctrl  (out_ctrl4),
    .stall     (stall),
    .flush     (flush),
    .stall_cnt (stall_cnt4)
  );

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Scoreboard: inputs are stable here, so this predicts the
  // coming edge and checks the outputs of the previous one.
  always @(negedge clk) begin
    logic mv;
    logic rdy;
    logic ofire;
    if (!rst) begin
      q.delete();
      exp_cnt  = 0;
      exp_cnt4 = 0;
    end else begin
      mv = (q.size() != 0);
`ifdef PIPE_STAGE_SKID_EN
      rdy = !stall && (q.size() < 2);
`else
      rdy = !stall && (!mv || out_ready);
`endif
      ofire = mv && out_ready && !stall;
      chk("valid", out_valid, mv);
      chk("ready", in_ready, rdy);
      chk("cnt", stall_cnt, exp_cnt);
      chk("cnt4", stall_cnt4, exp_cnt4);
      if (mv) begin
        chk("data", out_data, q[0].d);
        chk("ctrl", out_ctrl, q[0].c);
      end else begin
        chk("bubble", out_ctrl, 64'd0);
      end
      if (mv && (!out_ready || stall)) begin
        if (exp_cnt < 65535) exp_cnt++;
        if (exp_cnt4 < 15) exp_cnt4++;
      end
      if (ofire) void'(q.pop_front());
      if (flush) q.delete();
      else if (in_valid && rdy)
        q.push_back({in_ctrl, in_data});
    end
  end

  initial begin
    rst = 1'b1;
    #1 rst = 1'b0;
    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_ready", in_ready, 0);
    chk("rst_ctrl", out_ctrl, 0);
    chk("rst_data", out_data, 0);
    chk("rst_cnt", stall_cnt, 0);
    step(2);
    rst = 1'b1;

    // one-cycle latency
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 32'h1000_0004;
    in_ctrl   = 8'h11;
    step(1);
    chk("lat_valid", out_valid, 1);
    chk("lat_data", out_data, 32'h1000_0004);
    in_valid = 1'b0;
    step(1);

    // back-pressure holds data and counts
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'hCAFE_0001;
    in_ctrl   = 8'h22;
    step(1);
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(1);
      chk("bp_hold", out_data, 32'hCAFE_0001);
    end
    chk("bp_cnt3", stall_cnt, 3);

    // stall freezes both sides
    stall     = 1'b1;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 32'hBEEF_0002;
    in_ctrl   = 8'h44;
    #1;
    chk("stall_rdy", in_ready, 0);
    step(1);
    chk("stall_vld", out_valid, 1);
    chk("stall_data", out_data, 32'hCAFE_0001);
    stall    = 1'b0;
    in_valid = 1'b0;
    step(1);

    // flush beats a simultaneous in_fire
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'h0000_5555;
    in_ctrl   = 8'h33;
    step(1);
    flush     = 1'b1;
    out_ready = 1'b1;
    in_data   = 32'hDEAD_0000;
    in_ctrl   = 8'hFF;
    #1;
    chk("fl_rdy", in_ready, 1);
    step(1);
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("fl_valid", out_valid, 0);
    chk("fl_ctrl", out_ctrl, 0);
    chk("fl_data", out_data, 32'h0000_5555);

`ifdef PIPE_STAGE_SKID_EN
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'hAAAA_0001;
    in_ctrl   = 8'h0A;
    step(1);
    in_data = 32'hBBBB_0002;
    in_ctrl = 8'h0B;
    #1;
    chk("sk_rdy1", in_ready, 1);
    step(1);
    in_data = 32'hCCCC_0003;
    #1;
    chk("sk_rdy2", in_ready, 0);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk("sk_headA", out_data, 32'hAAAA_0001);
    step(1);
    chk("sk_headB", out_data, 32'hBBBB_0002);
    step(1);
    chk("sk_empty", out_valid, 0);
`else
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'hAAAA_0001;
    in_ctrl   = 8'h0A;
    step(1);
    in_data = 32'hBBBB_0002;
    #1;
    chk("full_rdy", in_ready, 0);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step(1);
    chk("full_drain", out_valid, 0);
`endif

    // random traffic against the scoreboard
    for (int i = 0; i < 300; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      stall     = ($urandom_range(0, 7) == 0);
      flush     = ($urandom_range(0, 15) == 0);
      in_data   = $urandom;
      in_ctrl   = 8'($urandom);
      step(1);
    end
    in_valid  = 1'b0;
    stall     = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    step(3);

    // saturation with a 4-bit counter
    rst = 1'b0;
    step(1);
    rst       = 1'b1;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'h0000_0042;
    in_ctrl   = 8'h42;
    step(1);
    in_valid = 1'b0;
    step(20);
    chk("sat_cnt4", stall_cnt4, 15);
    chk("cnt20", stall_cnt, 20);

    // reset mid-run clears outputs at once
    rst = 1'b0;
    #1;
    chk("mr_valid", out_valid, 0);
    chk("mr_ctrl", out_ctrl, 0);
    chk("mr_data", out_data, 0);
    chk("mr_cnt", stall_cnt, 0);
    chk("mr_cnt4", stall_cnt4, 0);
    chk("mr_ready", in_ready, 0);
    chk("mr_valid4", out_valid4, 0);
    step(1);
    rst       = 1'b1;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 32'h0000_0077;
    in_ctrl   = 8'h77;
    step(1);
    chk("resume_vld", out_valid, 1);
    chk("resume_data", out_data, 32'h0000_0077);
    in_valid = 1'b0;
    step(3);
    chk("end_empty", out_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
